// File: rtl/vid_timing_rx.sv
// Video timing receiver: measures sync geometry, indexes active pixels,
// sums frame data and tracks geometry lock across frames.
module vid_timing_rx #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             i_vs,
    input  logic             i_hs,
    input  logic             i_de,
    input  logic [7:0]       i_data,
    output logic             o_pix_valid,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic [7:0]       o_data,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_total,
    output logic [CNT_W-1:0] o_v_active,
    output logic             o_locked,
    output logic             o_frame_start,
    output logic [31:0]      o_frame_sum,
    output logic             o_sum_valid,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic             vs_r, hs_r, de_r, vs_d, hs_d;
    logic [7:0]       data_r;
    logic             vs_fall, hs_fall;
    logic [CNT_W-1:0] h_cnt, h_last, line_de, h_act_last, v_cnt, v_act, y_cur;
    logic             line_has, sat;
    logic [31:0]      acc;
    logic [CNT_W-1:0] h_tot_eff, h_act_eff, v_tot_eff;
    logic             sat_eff, match;
    logic [CNT_W-1:0] lde_base, va_base;
    logic             lh_base;
    logic [CNT_W-1:0] ref_ht, ref_ha, ref_vt, ref_va;
    state_t           state, state_n;
    logic [15:0]      cnt, cnt_n;
    logic             ld_ref, err_n, upd;

    assign vs_fall = vs_d & ~vs_r;
    assign hs_fall = hs_d & ~hs_r;

    // A line ending in the boundary cycle still belongs to the ending frame.
    assign h_tot_eff = hs_fall ? h_cnt : h_last;
    assign h_act_eff = line_has ? line_de : h_act_last;
    assign v_tot_eff = hs_fall ? inc_sat(v_cnt) : v_cnt;
    assign sat_eff   = sat | (h_tot_eff == CMAX) | (h_act_eff == CMAX)
                     | (v_tot_eff == CMAX) | (v_act == CMAX);
    assign match     = !sat_eff && h_tot_eff == ref_ht && h_act_eff == ref_ha
                     && v_tot_eff == ref_vt && v_act == ref_va;

    // A de cycle coinciding with a boundary starts the new line/frame.
    assign lh_base  = (hs_fall | vs_fall) ? 1'b0 : line_has;
    assign lde_base = (hs_fall | vs_fall) ? '0 : line_de;
    assign va_base  = vs_fall ? '0 : v_act;

    // Input registers and their delayed copies for edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= 1'b0; hs_r <= 1'b0; de_r <= 1'b0; data_r <= '0;
            vs_d <= 1'b0; hs_d <= 1'b0;
        end else begin
            vs_r <= i_vs; hs_r <= i_hs; de_r <= i_de; data_r <= i_data;
            vs_d <= vs_r; hs_d <= hs_r;
        end
    end

    // Line/frame measurement counters, pixel indexing and data sum.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0; h_last <= '0; line_de <= '0; h_act_last <= '0;
            v_cnt <= '0; v_act <= '0; y_cur <= '0; line_has <= 1'b0;
            sat <= 1'b0; acc <= '0;
            o_pix_valid <= 1'b0; o_x <= '0; o_y <= '0; o_data <= '0;
        end else begin
            o_pix_valid <= de_r;
            o_data      <= data_r;
            if (hs_fall) begin
                h_last <= h_cnt;
                h_cnt  <= 1;
            end else begin
                h_cnt <= inc_sat(h_cnt);
            end
            if (vs_fall)
                h_act_last <= '0;
            else if (hs_fall && line_has)
                h_act_last <= line_de;
            if (vs_fall)
                v_cnt <= '0;
            else if (hs_fall)
                v_cnt <= inc_sat(v_cnt);
            if (vs_fall)
                sat <= 1'b0;
            else if (hs_fall && (h_cnt == CMAX || line_de == CMAX))
                sat <= 1'b1;
            if (vs_fall)
                acc <= de_r ? {24'd0, data_r} : 32'd0;
            else if (de_r)
                acc <= acc + {24'd0, data_r};
            if (de_r) begin
                o_x      <= lde_base;
                line_de  <= inc_sat(lde_base);
                line_has <= 1'b1;
                if (!lh_base) begin
                    o_y   <= va_base;
                    y_cur <= va_base;
                    v_act <= inc_sat(va_base);
                end else begin
                    o_y   <= y_cur;
                    v_act <= va_base;
                end
            end else begin
                line_de  <= lde_base;
                line_has <= lh_base;
                v_act    <= va_base;
            end
        end
    end

    // Lock FSM: next state and frame-boundary actions.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ld_ref  = 1'b0;
        err_n   = 1'b0;
        upd     = 1'b0;
        if (vs_fall) begin
            unique case (state)
                SEARCH: state_n = MEASURE;
                MEASURE: begin
                    upd     = 1'b1;
                    ld_ref  = 1'b1;
                    cnt_n   = 16'd1;
                    state_n = (LOCK_FRAMES <= 1) ? LOCKED : CHECK;
                end
                CHECK: begin
                    upd = 1'b1;
                    if (match) begin
                        cnt_n = cnt + 16'd1;
                        if (cnt + 16'd1 >= 16'(LOCK_FRAMES))
                            state_n = LOCKED;
                    end else begin
                        cnt_n  = 16'd1;
                        ld_ref = 1'b1;
                    end
                end
                LOCKED: begin
                    upd = 1'b1;
                    if (!match) begin
                        err_n   = 1'b1;
                        cnt_n   = 16'd1;
                        ld_ref  = 1'b1;
                        state_n = CHECK;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    // FSM state, reference geometry and frame-level outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH; cnt <= '0;
            ref_ht <= '0; ref_ha <= '0; ref_vt <= '0; ref_va <= '0;
            o_h_total <= '0; o_h_active <= '0;
            o_v_total <= '0; o_v_active <= '0;
            o_frame_sum <= '0; o_sum_valid <= 1'b0;
            o_frame_start <= 1'b0; o_err <= 1'b0; o_locked <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            o_sum_valid   <= upd;
            o_frame_start <= upd;
            o_err         <= err_n;
            o_locked      <= (state_n == LOCKED);
            if (ld_ref) begin
                ref_ht <= h_tot_eff; ref_ha <= h_act_eff;
                ref_vt <= v_tot_eff; ref_va <= v_act;
            end
            if (upd) begin
                o_h_total   <= h_tot_eff;
                o_h_active  <= h_act_eff;
                o_v_total   <= v_tot_eff;
                o_v_active  <= v_act;
                o_frame_sum <= acc;
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_rx.sv
// Scoreboard bench for vid_timing_rx on a reduced raster
// (50x33 total, 40x24 active) so every scenario runs in few cycles.
module tb_vid_timing_rx;

    localparam int W      = 12;
    localparam int V_TOT  = 33;
    localparam int H_TOT  = 50;
    localparam int H_ACT  = 40;
    localparam int V_ACT  = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_vs = 1'b1, i_hs = 1'b1, i_de = 1'b0;
    logic [7:0]    i_data = '0;
    logic          o_pix_valid, o_locked, o_frame_start, o_sum_valid, o_err;
    logic [W-1:0]  o_x, o_y, o_h_total, o_h_active, o_v_total, o_v_active;
    logic [7:0]    o_data;
    logic [31:0]   o_frame_sum;

    typedef struct {
        int          t;
        logic [31:0] sum;
        logic [47:0] geom;
        logic        lock;
        logic        err;
    } fexp_t;

    logic [63:0] pq[$];
    fexp_t       fq[$];
    int          cyc = 0;
    int          nchk = 0;
    int          nerr = 0;
    int          nb = 0;
    logic [31:0] psum;
    int          pht, pha, pva;

    vid_timing_rx #(.CNT_W(W), .LOCK_FRAMES(2)) dut (
        .clk_i(clk), .rst_n(rst_n),
        .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de), .i_data(i_data),
        .o_pix_valid(o_pix_valid), .o_x(o_x), .o_y(o_y), .o_data(o_data),
        .o_h_total(o_h_total), .o_h_active(o_h_active),
        .o_v_total(o_v_total), .o_v_active(o_v_active),
        .o_locked(o_locked), .o_frame_start(o_frame_start),
        .o_frame_sum(o_frame_sum), .o_sum_valid(o_sum_valid), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to verify output latency.
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Pop and compare scoreboard entries as the DUT emits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_pix_valid) begin
                if (pq.size() == 0)
                    check("pix_extra", 64'(o_x), 64'hFFFF_FFFF);
                else
                    check("pix", {32'(cyc), o_x, o_y, o_data}, pq.pop_front());
            end
            if (o_frame_start) begin
                if (fq.size() == 0) begin
                    check("frm_extra", 1, 0);
                end else begin
                    fexp_t fe;
                    fe = fq.pop_front();
                    check("frm_time", 64'(cyc), 64'(fe.t));
                    check("sum_valid", 64'(o_sum_valid), 1);
                    check("frame_sum", 64'(o_frame_sum), 64'(fe.sum));
                    check("geometry", {o_h_total, o_h_active, o_v_total,
                                       o_v_active}, 64'(fe.geom));
                    check("locked", 64'(o_locked), 64'(fe.lock));
                    check("err", 64'(o_err), 64'(fe.err));
                end
            end else if (o_sum_valid || o_err) begin
                check("stray_pulse", {o_sum_valid, o_err}, 0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        i_vs = 1'b1; i_hs = 1'b1; i_de = 1'b0; i_data = '0;
        #1;
        check("rst_pix", {o_pix_valid, o_x, o_y, o_data}, 0);
        check("rst_flags", {o_locked, o_frame_start, o_sum_valid, o_err}, 0);
        check("rst_geom", {o_h_total, o_h_active, o_v_total, o_v_active}, 0);
        check("rst_sum", 64'(o_frame_sum), 0);
        pq.delete();
        fq.delete();
        nb = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // One frame starting with vs low on line 0; the boundary it opens
    // reports the previous frame, with elock/eerr expected at that point.
    task automatic drive_frame(input int ht, input int va, input bit coin,
                               input bit ramp, input bit elock,
                               input bit eerr, input int nlines);
        logic [31:0] s;
        logic [7:0]  d;
        bit          de, hs_lo;
        int          x;
        s = '0;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < ht; p++) begin
                @(posedge clk);
                #1;
                hs_lo = coin ? (p < 4) : (p >= H_ACT + 2 && p < H_ACT + 6);
                de = (l >= 3) && (l < 3 + va) &&
                     (coin ? (p >= 8 && p < 8 + H_ACT) : (p < H_ACT));
                x = coin ? p - 8 : p;
                d = ramp ? 8'(p * 3 + l) : 8'h10;
                i_vs = !(l < 2);
                i_hs = !hs_lo;
                i_de = de;
                i_data = de ? d : 8'hA5;
                if (l == 0 && p == 0 && nb > 0) begin
                    fexp_t e;
                    e.t = cyc + 2;
                    e.sum = psum;
                    e.geom = {12'(pht), 12'(pha), 12'(V_TOT), 12'(pva)};
                    e.lock = elock;
                    e.err = eerr;
                    fq.push_back(e);
                end
                if (de) begin
                    pq.push_back({32'(cyc + 2), 12'(x), 12'(l - 3), d});
                    s += {24'd0, d};
                end
            end
        end
        nb++;
        psum = s;
        pht = ht;
        pha = (va > 0) ? H_ACT : 0;
        pva = va;
    endtask

    initial begin
        do_reset();
        // acquire lock with constant data
        drive_frame(H_TOT, V_ACT, 0, 0, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 0, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 0, 1, 0, V_TOT);
        check("const_sum_model", 64'(psum), 64'(H_ACT * V_ACT * 16));
        drive_frame(H_TOT, V_ACT, 0, 1, 1, 0, V_TOT);
        // one long-line frame breaks lock, then relock
        drive_frame(H_TOT + 1, V_ACT, 0, 1, 1, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 0, 1, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 0, 0, V_TOT);
        // frame without de: zero geometry/sum, breaks lock
        drive_frame(H_TOT, 0, 0, 1, 1, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 0, 1, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 1, 0, V_TOT);
        // reset in the middle of a locked frame
        drive_frame(H_TOT, V_ACT, 0, 1, 1, 0, 10);
        do_reset();
        drive_frame(H_TOT, V_ACT, 0, 1, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 0, 1, 1, 0, V_TOT);
        // hs and vs falling together
        do_reset();
        drive_frame(H_TOT, V_ACT, 1, 1, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 1, 1, 0, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 1, 1, 1, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 1, 1, 1, 0, V_TOT);
        drive_frame(H_TOT, V_ACT, 1, 1, 1, 0, V_TOT);
        repeat (5) @(posedge clk);
        #1;
        check("pix_left", 64'(pq.size()), 0);
        check("frm_left", 64'(fq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
